// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 data mux into one registered output stage.
// Grants are capped at BURST beats, and every re-arbitration spends one IDLE cycle.
module mux_rr_arbiter #(
    parameter int DATA_W = 8,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        in_valid,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic [3:0]        in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        sel,
    output logic              busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] BURST_CNT = 4'(BURST);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [DATA_W-1:0] sel_data;
    logic              can_load;
    logic              xfer;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic              found;

    // First valid requester at or above ptr, wrapping modulo 4.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        idx    = ptr_q;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && in_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    sel_data = in_data0;
            2'd1:    sel_data = in_data1;
            2'd2:    sel_data = in_data2;
            default: sel_data = in_data3;
        endcase
    end

    // Ready depends only on state, sel and the output register, never on in_valid.
    assign can_load = !out_valid_q || out_ready;
    assign in_ready = (state_q == GRANT && can_load) ? (4'b0001 << sel_q) : '0;
    assign xfer     = (state_q == GRANT) && can_load && in_valid[sel_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d      = winner;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
                if (!in_valid[sel_q] || (xfer && (beat_cnt_q + 4'd1 == BURST_CNT))) begin
                    state_d = IDLE;
                    ptr_d   = sel_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: producer queues feed requesters,
// and a monitor checks every accepted output beat against hand-ordered expectations.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [7:0] din [4];
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] sel;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] pq [4][$];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_W(8), .BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (din[0]),
        .in_data1  (din[1]),
        .in_data2  (din[2]),
        .in_data3  (din[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic feed(input int req, input logic [7:0] d);
        pq[req].push_back(d);
    endtask

    task automatic expect_beat(input logic [7:0] d);
        exp_q.push_back(d);
    endtask

    task automatic flush_all();
        exp_q.delete();
        for (int i = 0; i < 4; i++) pq[i].delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        flush_all();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d beats still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Producers: hand-shake sampled mid-cycle, queue advanced just after the edge.
    initial begin
        logic [3:0] hs;
        in_valid = '0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        forever begin
            @(negedge clk);
            hs = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                if (pq[i].size() > 0) begin
                    in_valid[i] = 1'b1;
                    din[i]      = pq[i][0];
                end else begin
                    in_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: a beat is consumed on the next edge when out_valid && out_ready.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: got unexpected 0x%0h, expected no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL beat: got 0x%0h, expected 0x%0h at %0t", out_data, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data",  32'(out_data),  0);
        check("reset in_ready",  32'(in_ready),  0);
        check("reset busy",      32'(busy),      0);
        check("reset sel",       32'(sel),       0);
        do_reset();

        // Single requester: req2 sends 0xA5.
        @(negedge clk);
        feed(2, 8'hA5); expect_beat(8'hA5);
        @(negedge clk);
        check("single c0 busy", 32'(busy), 0);
        check("single c0 in_ready", 32'(in_ready), 0);
        @(negedge clk);
        check("single c1 sel", 32'(sel), 2);
        check("single c1 in_ready", 32'(in_ready), 32'h4);
        check("single c1 busy", 32'(busy), 1);
        @(negedge clk);
        check("single c2 out_valid", 32'(out_valid), 1);
        check("single c2 in_ready", 32'(in_ready), 32'h4);
        @(negedge clk);
        check("single c3 busy", 32'(busy), 0);
        check("single c3 in_ready", 32'(in_ready), 0);
        drain("single", 50);

        // All four at once after reset, then req0 again: order 0,1,2,3,0.
        do_reset();
        feed(0, 8'h01); feed(1, 8'h11); feed(2, 8'h21); feed(3, 8'h31);
        expect_beat(8'h01); expect_beat(8'h11); expect_beat(8'h21); expect_beat(8'h31);
        drain("all four", 100);
        feed(0, 8'h02); expect_beat(8'h02);
        drain("rewrap", 50);

        // Burst cap: req1 1..4, req3, then req1 5..8.
        do_reset();
        for (int i = 1; i <= 8; i++) feed(1, 8'(i));
        feed(3, 8'hC1); feed(3, 8'hC2);
        for (int i = 1; i <= 4; i++) expect_beat(8'(i));
        expect_beat(8'hC1); expect_beat(8'hC2);
        for (int i = 5; i <= 8; i++) expect_beat(8'(i));
        drain("burst", 200);

        // Backpressure after the first beat.
        do_reset();
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            feed(0, 8'(8'h40 + i)); expect_beat(8'(8'h40 + i));
        end
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp out_data held", 32'(out_data), 32'h41);
            check("bp out_valid held", 32'(out_valid), 1);
            check("bp in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain("backpressure", 100);

        // Early release: req0 drops after 2 beats, ptr moves to 1.
        do_reset();
        @(negedge clk);
        feed(0, 8'h51); feed(0, 8'h52); feed(1, 8'h61);
        expect_beat(8'h51); expect_beat(8'h52); expect_beat(8'h61); expect_beat(8'h53);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        feed(0, 8'h53);
        @(negedge clk);
        check("early c4 busy", 32'(busy), 0);
        @(negedge clk);
        check("early c5 sel", 32'(sel), 1);
        check("early c5 busy", 32'(busy), 1);
        drain("early", 100);

        // Reset mid-burst after moving ptr to 3.
        do_reset();
        feed(2, 8'h82); expect_beat(8'h82);
        drain("pre-reset", 50);
        for (int i = 1; i <= 4; i++) begin
            feed(1, 8'(8'h70 + i)); expect_beat(8'(8'h70 + i));
        end
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("midburst busy", 32'(busy), 1);
        check("midburst out_valid", 32'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async out_valid", 32'(out_valid), 0);
        check("async out_data",  32'(out_data),  0);
        check("async in_ready",  32'(in_ready),  0);
        check("async busy",      32'(busy),      0);
        check("async sel",       32'(sel),       0);
        flush_all();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        feed(3, 8'hA3); feed(0, 8'hA0);
        expect_beat(8'hA0); expect_beat(8'hA3);
        drain("post-reset", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
